// File: rtl/sdram_readback_check.sv
// sdram_readback_check
//   Sweeps an SDRAM word range through the controller read port and
//   compares each returned word against a constant. It reports the mismatch
//   count, the first failing address and data, and done/pass status.
//
// Ports
//   clk_sys, RESET        clock; synchronous active-high reset
//   start, abort          sweep control (abort wins over start and compare)
//   start_addr, end_addr  inclusive word range, latched on accepted start
//   expect_data           expected word, latched on accepted start
//   sdram_addr, sdram_rd  read request to the controller (registered)
//   sdram_ready           controller idle / read data valid
//   sdram_dout            read data, sampled in WAIT when ready
//   busy, done, pass      status (done held until next start or reset)
//   err_cnt               saturating mismatch count
//   first_err_addr/_data  location and value of the first mismatch
//   cur_addr              address currently being checked
module sdram_readback_check #(
  parameter int AW = 27,
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic [DW-1:0] expect_data,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_rd,
  input  logic          sdram_ready,
  input  logic [DW-1:0] sdram_dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data,
  output logic [AW-1:0] cur_addr
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] end_q, end_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [15:0]   err_q, err_d;
  logic [AW-1:0] ferr_addr_q, ferr_addr_d;
  logic [DW-1:0] ferr_data_q, ferr_data_d;

  // State and all registered outputs
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      end_q       <= '0;
      exp_q       <= '0;
      cur_q       <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      end_q       <= end_d;
      exp_q       <= exp_d;
      cur_q       <= cur_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort)
                 state_d = (end_addr < start_addr) ? S_DONE : S_ISSUE;
      S_ISSUE: if (abort) state_d = S_IDLE;
               else if (sdram_ready) state_d = S_GAP;
      S_GAP:   state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT:  if (abort) state_d = S_IDLE;
               else if (sdram_ready) state_d = (cur_q == end_q) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    end_d       = end_q;
    exp_d       = exp_q;
    cur_d       = cur_q;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    busy_d      = (state_d == S_ISSUE) || (state_d == S_GAP) || (state_d == S_WAIT);
    unique case (state_q)
      S_IDLE: if (start && !abort) begin
        end_d       = end_addr;
        exp_d       = expect_data;
        cur_d       = start_addr;
        err_d       = '0;
        ferr_addr_d = '0;
        ferr_data_d = '0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
      end
      // rd is registered, so it is visible during the GAP cycle only
      S_ISSUE: if (!abort && sdram_ready) begin
        rd_d   = 1'b1;
        addr_d = cur_q;
      end
      S_WAIT: if (!abort && sdram_ready) begin
        if (sdram_dout != exp_q) begin
          if (err_q == '0) begin
            ferr_addr_d = cur_q;
            ferr_data_d = sdram_dout;
          end
          if (err_q != '1) err_d = err_q + 16'd1;
        end
        // Equality test before increment: an all-ones end never wraps
        if (cur_q != end_q) cur_d = cur_q + AW'(1);
      end
      S_DONE: begin
        done_d = 1'b1;
        pass_d = (err_q == '0);
      end
      default: ;
    endcase
  end

  assign sdram_addr     = addr_q;
  assign sdram_rd       = rd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;
  assign cur_addr       = cur_q;

endmodule

// File: doc/sdram_readback_check.md
# sdram_readback_check

Read-side companion to the menu core's SDRAM probe/clear writer. After the writer has filled a region of SDRAM with a constant, this block sweeps the same address range through the `sdram` controller's read port and compares every returned word against the expected value. It reports the error count, the first failing address and data, and pass/done status, which firmware reads through status/cfg bits. It owns the controller's `addr`/`rd` inputs only while busy; the top level muxes it against the writer, with the writer idle.

## Interface
Parameters:
- `AW`, 27: SDRAM word-address width.
- `DW`, 16: SDRAM data width.

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a sweep when idle, ignored while busy.
- `abort`  in  1  stops the sweep at the next edge.
- `start_addr`  in  AW  first word address; latched on an accepted `start`.
- `end_addr`  in  AW  last word address, inclusive; latched on an accepted `start`.
- `expect_data`  in  DW  expected word; latched on an accepted `start`.
- `sdram_addr`  out  AW  read address to the controller.
- `sdram_rd`  out  1  one-cycle read request.
- `sdram_ready`  in  1  controller idle / read data valid.
- `sdram_dout`  in  DW  read data; sampled only in WAIT when `sdram_ready`=1.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep completed normally; held until the next accepted `start` or reset.
- `pass`  out  1  `done` & (`err_cnt`==0).
- `err_cnt`  out  16  mismatch count, saturating at 16'hFFFF.
- `first_err_addr`  out  AW  address of the first mismatch.
- `first_err_data`  out  DW  data read at the first mismatch.
- `cur_addr`  out  AW  address currently being checked (progress).

## Operation
- State machine states: IDLE, ISSUE, GAP, WAIT, DONE.
- IDLE:
  - On `start`: latch the inputs, clear `err_cnt`, `first_err_*`, `done` and `pass`, and load `cur_addr`←`start_addr`.
  - Go to DONE if `end_addr` < `start_addr`. In that case no reads are issued and the sweep passes.
  - Otherwise go to ISSUE.
- ISSUE: wait for `sdram_ready`=1. Then drive `sdram_addr`=`cur_addr` and `sdram_rd`=1 for exactly one cycle, and go to GAP.
- GAP: one cycle, unconditional. This covers the controller's one-cycle delay in dropping `ready` after `rd`. Go to WAIT.
- WAIT: wait for `sdram_ready`=1, then compare `sdram_dout` with the latched expect value.
  - On mismatch: if `err_cnt`==0, capture `first_err_addr`=`cur_addr` and `first_err_data`=`sdram_dout`. Then increment `err_cnt`, saturating.
  - If `cur_addr`==latched end, go to DONE. Otherwise `cur_addr`+1 and go to ISSUE.
  - The end test is an equality check before increment, so `end_addr`=all-ones never wraps.
- DONE:
  - Set `done`=1; `pass` follows from `err_cnt`.
  - Go to IDLE in the same cycle; `done` stays held.
  - A new `start` is accepted on the cycle after DONE.
- `abort`, when busy: go to IDLE and drop `sdram_rd`. `done` stays 0. `err_cnt` and `first_err_*` keep their partial values. `abort` has priority over `start` and over the WAIT compare in the same cycle.
- `busy`=1 in ISSUE, GAP and WAIT.
- `sdram_rd` is never high in two consecutive cycles.

## Timing
- Reset values: state IDLE. `sdram_rd`=0, `sdram_addr`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_addr`=0, `first_err_data`=0, `cur_addr`=0.
- Reset mid-sweep: all outputs return to their reset values at the next edge. The read still in flight inside the controller is discarded and never compared.
- `start` at edge T: `busy`=1 at T+1, and `sdram_rd` at T+2 at the earliest.
- Per word with `ready` returning R cycles after `rd`: ISSUE 1 + GAP 1 + WAIT max(1, R−1) cycles. The minimum is 3 cycles per word.
- `err_cnt` and `first_err_*` update on the edge after the WAIT compare cycle.
- `done` and `pass` are valid one edge after the last compare.
- All outputs are registered.

## Test plan
- Clean region: controller model with `ready` low for 4 cycles after `rd`. Memory is all 0. Sweep `start_addr`=0, `end_addr`=15, `expect_data`=0.
  - Required: 16 `rd` pulses at addresses 0..15 in order; then `done`=1, `pass`=1, `err_cnt`=0.
- Single fault: memory word 7 = 16'h1234 and all others 0. Sweep 0..15.
  - Required: `err_cnt`=1, `first_err_addr`=7, `first_err_data`=16'h1234, `pass`=0.
- Multiple faults: words 3, 9 and 12 are nonzero.
  - Required: `err_cnt`=3, `first_err_addr`=3.
- Boundaries:
  - `start_addr`=`end_addr`=27'h7FFFFFF: exactly one read, then `done`.
  - `start_addr`=5, `end_addr`=4: no reads, and `done`=1, `pass`=1 two edges after `start`.
- Abort: assert `abort` in the WAIT state for address 3.
  - Required: `sdram_rd` stays 0 from then on, `busy`=0, `done`=0.
  - A following `start` with 0..1 completes normally.
- Reset mid-sweep: pulse `RESET` during GAP.
  - Required: all outputs at reset values next edge, and no further `rd`.
- Continuous checks: `start` while busy has no effect, and `sdram_rd` is never high in two consecutive cycles.
